// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes data_a - data_b one bit per cycle, LSB first.
// The result and final borrow are published together on the completion edge and held until
// the next completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             bout
);

  // One extra bit so the counter can represent WIDTH itself and never wraps mid-operation.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              brw_q, brw_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              bout_q, bout_d;

  logic              diff_bit;
  logic              brw_nxt;

  // Full-subtractor cell operating on the current LSBs and the stored borrow.
  assign diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

  // Next-state logic: operand capture, per-bit shifting and result publication.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = data_a;
          b_d     = data_b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        brw_d = brw_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last bit: publish the completed difference and borrow on this same edge.
          out_d   = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = brw_nxt;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign out  = out_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle-level arithmetic model is compared with the
// DUT on every falling edge, and directed operations check literal results and latency.
module tb_serial_subtractor;

  localparam int unsigned W = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  data_a;
  logic [W-1:0]  data_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  out;
  logic          bout;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_a (data_a),
    .data_b (data_b),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .bout   (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operation is busy for W cycles, then done for one cycle carrying
  // the plain arithmetic difference and the unsigned less-than borrow.
  int           m_run;
  logic         m_done;
  logic [W-1:0] m_a, m_b, m_out;
  logic         m_bout;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
      m_bout <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
    end else if (m_run > 0) begin
      if (m_run == 1) begin
        m_done <= 1'b1;
        m_out  <= m_a - m_b;
        m_bout <= (m_a < m_b);
      end
      m_run <= m_run - 1;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_a   <= data_a;
        m_b   <= data_b;
        m_run <= W;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_run > 0));
    check("done", 64'(done), 64'(m_done));
    check("out",  64'(out),  64'(m_out));
    check("bout", 64'(bout), 64'(m_bout));
  end

  // Launch one operation and check result literals plus accept-to-done latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_out, input logic exp_bout);
    int k;
    bit seen;
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= W + 5; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 64'(0), 64'(1));
    end else begin
      check("latency", 64'(k), 64'(W + 1));
      check("op_out", 64'(out), 64'(exp_out));
      check("op_bout", 64'(bout), 64'(exp_bout));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int prev;
    int ndone;
    logic [W-1:0] ra, rb;

    reset  = 1'b1;
    start  = 1'b0;
    data_a = '0;
    data_b = '0;
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_out",  64'(out),  64'(0));
    check("rst_bout", 64'(bout), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed literal vectors.
    run_op(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    check("model_pin_zero", 64'(m_out), 64'(16'h0000));
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    check("model_pin_borrow", 64'({m_bout, m_out}), 64'(17'h1FFFF));
    run_op(16'h500A, 16'h400A, 16'h1000, 1'b0);
    run_op(16'h0001, 16'h8000, 16'h8001, 1'b1);

    // Held start: back-to-back every W+1 cycles; mid-RUN operand change must not leak.
    @(negedge clk);
    data_a = 16'h0005;
    data_b = 16'h0003;
    start  = 1'b1;
    prev   = 0;
    ndone  = 0;
    for (int c = 1; c <= 80 && ndone < 3; c++) begin
      @(negedge clk);
      if (c == 5) data_a = 16'h0009;
      if (c == 10) data_a = 16'h0005;
      if (done) begin
        ndone++;
        check("b2b_out", 64'(out), 64'(16'h0002));
        check("b2b_bout", 64'(bout), 64'(0));
        if (prev == 0) check("b2b_first", 64'(c), 64'(W + 1));
        else check("b2b_period", 64'(c - prev), 64'(W + 1));
        prev = c;
      end
    end
    check("b2b_count", 64'(ndone), 64'(3));
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Abort mid-RUN with asynchronous reset; start held high during reset is ignored.
    run_op(16'h1234, 16'h0034, 16'h1200, 1'b0);
    @(negedge clk);
    data_a = 16'hABCD;
    data_b = 16'h0001;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_out",  64'(out),  64'(0));
    check("abort_bout", 64'(bout), 64'(0));
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'(0));
    end
    run_op(16'h1234, 16'h0234, 16'h1000, 1'b0);

    // Random operands against plain arithmetic.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) rb = ra;
      run_op(ra, rb, ra - rb, (ra < rb));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 16, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a subtraction.
REQ-005 The block SHALL have port data_a, input, WIDTH bits: the minuend, unsigned.
REQ-006 The block SHALL have port data_b, input, WIDTH bits: the subtrahend, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that out and bout are valid.
REQ-009 The block SHALL have port out, output, WIDTH bits: the difference data_a - data_b, modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: the final borrow; 1 when data_a < data_b (unsigned).

Function
REQ-011 The block SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 SHALL be accepted at the clock edge; that edge SHALL:
- latch data_a and data_b into internal shift registers;
- clear the internal borrow flip-flop and the bit counter;
- move the state to RUN.
REQ-013 In RUN, each edge SHALL process one bit, LSB first, with a0 = operand A shift-register bit 0, b0 = operand B shift-register bit 0, br = borrow flip-flop:
- d = a0 ^ b0 ^ br;
- borrow_next = (~a0 & b0) | (~(a0 ^ b0) & br);
- d SHALL be shifted into the MSB of an internal result register, and both operand registers SHALL shift right by one;
- the bit counter SHALL increment.
REQ-014 RUN SHALL last exactly WIDTH cycles. On the edge that processes bit WIDTH-1, the state SHALL move to DONE, and on that same edge out SHALL load the full result and bout SHALL load the final borrow.
REQ-015 done SHALL be 1 only while in DONE, for exactly one cycle. busy SHALL be 1 while in RUN and 0 otherwise.
REQ-016 Latency SHALL be as follows: start accepted at edge N means done is high during the cycle after edge N+WIDTH.
REQ-017 DONE SHALL return to IDLE on the next edge. If start=1 in DONE, it SHALL be accepted as in IDLE and the state SHALL go directly to RUN (back-to-back operation).
REQ-018 start SHALL be ignored while in RUN. data_a and data_b changes during RUN SHALL NOT affect the result in progress.
REQ-019 out and bout SHALL change only at the completion edge. They SHALL hold their values through subsequent IDLE and RUN periods until the next completion edge.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during an operation.

Reset
REQ-021 reset=1 SHALL immediately, without waiting for clk:
- force the state to IDLE;
- set busy=0, done=0, out=0 and bout=0;
- clear the operand registers, result register, borrow flip-flop and counter.
REQ-022 A reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after reset deassertion SHALL behave as from power-up.
REQ-023 start SHALL be ignored on any edge while reset=1.

Verification
REQ-024 With WIDTH=16: data_a=16'hFFFF, data_b=16'hFFFF, start pulse -> after 16 RUN cycles, done=1 for one cycle, out=16'h0000, bout=0.
REQ-025 With WIDTH=16: data_a=16'h0000, data_b=16'h0001 -> out=16'hFFFF, bout=1. With data_a=16'h500A, data_b=16'h400A -> out=16'h1000, bout=0.
REQ-026 Start held at 1 continuously with data_a=16'h0005, data_b=16'h0003 -> back-to-back operations with done every 17 cycles and out=16'h0002. Changing data_a to 16'h0009 mid-RUN SHALL NOT alter that operation's result.
REQ-027 Start accepted, then reset pulsed at RUN cycle 7 -> busy=0, out=0, bout=0 immediately and no done pulse. A new operation 16'h1234 - 16'h0234 SHALL then complete with out=16'h1000.
REQ-028 Random unsigned operand pairs (at least 1000) -> out == (data_a - data_b) mod 2^16 and bout == (data_a < data_b), checked against a reference model at every done pulse. The latency of REQ-016 SHALL be checked on every operation.
